// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: shadow-entry layout, stage indices and
// the register-match helper used by both the forwarding and load-use logic.
package pipe_hazard_ctrl_pkg;

  // Widest register address a shadow entry can hold; narrower register
  // addresses are zero-extended into it.
  localparam int SHADOW_AW = 8;

  // Forward-select encoding for "take the ID/EX register value".
  localparam int FWD_SEL_RF = 0;

  // Shadow indices of the named pipeline stages.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;

  typedef struct packed {
    logic                 valid;
    logic [SHADOW_AW-1:0] dest;
    logic                 reg_write;
    logic                 mem_read;
  } shadow_entry_t;

  // True when entry e will write register r and r is not the zero register.
  function automatic logic writes_reg(input shadow_entry_t e,
                                      input logic [SHADOW_AW-1:0] r);
    return e.valid && e.reg_write && (e.dest == r) && (r != {SHADOW_AW{1'b0}});
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step up on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline. A shadow shift register mirrors
// every instruction past ID; from it and the ID fields this block derives EX
// forwarding selects, load-use stall/bubble and taken-branch flushes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int  REG_AW    = 5,
  parameter int  FWD_DEPTH = 2,
  parameter int  LOAD_LAT  = 1,
  parameter int  CNT_W     = 16,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_stall,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Shadow stage k mirrors pipeline stage EX+k.
  shadow_entry_t shadow_q [0:FWD_DEPTH];
  shadow_entry_t shadow_d [0:FWD_DEPTH];

  // Source registers read by the instruction now in EX (0 when unused).
  logic [REG_AW-1:0] s0_rs_q, s0_rs_d;
  logic [REG_AW-1:0] s0_rt_q, s0_rt_d;

  // A flush last cycle means the instruction now in ID was squashed.
  logic flush_prev_q, flush_prev_d;

  logic                 id_entry_valid_s;
  logic [SHADOW_AW-1:0] id_rs_x_s;
  logic [SHADOW_AW-1:0] id_rt_x_s;
  logic [SHADOW_AW-1:0] s0_rs_x_s;
  logic [SHADOW_AW-1:0] s0_rt_x_s;
  logic                 luse_hit_s;
  logic                 luse_s;
  logic                 flush_s;
  logic                 stall_s;
  logic [FWD_DEPTH:1]   hit_a_s;
  logic [FWD_DEPTH:1]   hit_b_s;
  logic [SEL_W-1:0]     fwd_a_s;
  logic [SEL_W-1:0]     fwd_b_s;

  assign id_entry_valid_s = id_valid && !flush_prev_q;
  assign id_rs_x_s        = SHADOW_AW'(id_rs);
  assign id_rt_x_s        = SHADOW_AW'(id_rt);
  assign s0_rs_x_s        = SHADOW_AW'(s0_rs_q);
  assign s0_rt_x_s        = SHADOW_AW'(s0_rt_q);

  // A taken branch only counts while the pipe moves and a real branch sits in MEM.
  assign flush_s = branch_taken && shadow_q[STG_MEM].valid && !ext_stall;

  // Load-use detection: a load still inside its no-forward window feeds a used ID source.
  always_comb begin
    luse_hit_s = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      luse_hit_s = luse_hit_s |
                   (shadow_q[j].mem_read &
                    ((id_rs_used & writes_reg(shadow_q[j], id_rs_x_s)) |
                     (id_rt_used & writes_reg(shadow_q[j], id_rt_x_s))));
    end
    luse_s = id_entry_valid_s & luse_hit_s;
  end

  // The flush squashes the stalled instruction anyway, so flush wins.
  assign stall_s = luse_s && !flush_s;

  // Per-stage producer match for each EX operand.
  for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_fwd
    assign hit_a_s[k] = writes_reg(shadow_q[k], s0_rs_x_s);
    assign hit_b_s[k] = writes_reg(shadow_q[k], s0_rt_x_s);
  end

  // Forward select: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_a_s = SEL_W'(FWD_SEL_RF);
    fwd_b_s = SEL_W'(FWD_SEL_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      fwd_a_s = hit_a_s[k] ? SEL_W'(k) : fwd_a_s;
      fwd_b_s = hit_b_s[k] ? SEL_W'(k) : fwd_b_s;
    end
  end

  // Shadow advance: shift toward WB, kill EX on flush, load EX from ID or a bubble.
  always_comb begin
    shadow_d     = shadow_q;
    s0_rs_d      = s0_rs_q;
    s0_rt_d      = s0_rt_q;
    flush_prev_d = flush_prev_q;
    if (!ext_stall) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        shadow_d[k] = shadow_q[k-1];
      end
      shadow_d[STG_MEM] = flush_s ? '0 : shadow_q[STG_EX];
      if (id_entry_valid_s && !stall_s && !flush_s) begin
        shadow_d[STG_EX].valid     = 1'b1;
        shadow_d[STG_EX].dest      = SHADOW_AW'(id_dest);
        shadow_d[STG_EX].reg_write = id_reg_write;
        shadow_d[STG_EX].mem_read  = id_mem_read;
        s0_rs_d = id_rs_used ? id_rs : {REG_AW{1'b0}};
        s0_rt_d = id_rt_used ? id_rt : {REG_AW{1'b0}};
      end else begin
        shadow_d[STG_EX] = '0;
        s0_rs_d          = {REG_AW{1'b0}};
        s0_rt_d          = {REG_AW{1'b0}};
      end
      flush_prev_d = flush_s;
    end else begin
      shadow_d     = shadow_q;
      s0_rs_d      = s0_rs_q;
      s0_rt_d      = s0_rt_q;
      flush_prev_d = flush_prev_q;
    end
  end

  // Shadow state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        shadow_q[k] <= '0;
      end
      s0_rs_q      <= {REG_AW{1'b0}};
      s0_rt_q      <= {REG_AW{1'b0}};
      flush_prev_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      s0_rs_q      <= s0_rs_d;
      s0_rt_q      <= s0_rt_d;
      flush_prev_q <= flush_prev_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_s && !ext_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_s),
    .count (flush_cnt)
  );

  assign stall_ifid  = stall_s;
  assign bubble_idex = stall_s;
  assign flush_ifid  = flush_s;
  assign flush_idex  = flush_s;
  assign flush_exmem = flush_s;
  assign fwd_a_sel   = fwd_a_s;
  assign fwd_b_sel   = fwd_b_s;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Instance A: FWD_DEPTH=2, LOAD_LAT=1,
// CNT_W=4. Instance B: FWD_DEPTH=3, LOAD_LAT=2, CNT_W=16. Both see the same
// ID stream; each expectation names the instance it applies to.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_stall, id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, branch_taken;
  logic [4:0] id_rs, id_rt, id_dest;

  logic        a_stall, a_bub, a_fl_if, a_fl_id, a_fl_ex;
  logic [1:0]  a_fa, a_fb;
  logic [3:0]  a_sc, a_fc;
  logic        b_stall, b_bub, b_fl_if, b_fl_id, b_fl_ex;
  logic [1:0]  b_fa, b_fb;
  logic [15:0] b_sc, b_fc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall_ifid(a_stall), .bubble_idex(a_bub),
    .flush_ifid(a_fl_if), .flush_idex(a_fl_id), .flush_exmem(a_fl_ex),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_ctrl #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall_ifid(b_stall), .bubble_idex(b_bub),
    .flush_ifid(b_fl_if), .flush_idex(b_fl_id), .flush_exmem(b_fl_ex),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_cnt(b_sc), .flush_cnt(b_fc));

  typedef struct {
    bit dut;
    int id;
    bit stall;
    bit flush;
    int fa;
    int fb;
    int sc;
    int fc;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_id = 0;

  task automatic chk(input int id, input string fld, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step%0d %s: got %0d expected %0d", id, fld, act, exp);
    end
  endtask

  // Monitor: every negedge, compare the selected instance against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (!e.dut) begin
        chk(e.id, "A.stall_ifid",  32'(a_stall), int'(e.stall));
        chk(e.id, "A.bubble_idex", 32'(a_bub),   int'(e.stall));
        chk(e.id, "A.flush_ifid",  32'(a_fl_if), int'(e.flush));
        chk(e.id, "A.flush_idex",  32'(a_fl_id), int'(e.flush));
        chk(e.id, "A.flush_exmem", 32'(a_fl_ex), int'(e.flush));
        chk(e.id, "A.fwd_a_sel",   32'(a_fa),    e.fa);
        chk(e.id, "A.fwd_b_sel",   32'(a_fb),    e.fb);
        chk(e.id, "A.stall_cnt",   32'(a_sc),    e.sc);
        chk(e.id, "A.flush_cnt",   32'(a_fc),    e.fc);
      end else begin
        chk(e.id, "B.stall_ifid",  32'(b_stall), int'(e.stall));
        chk(e.id, "B.bubble_idex", 32'(b_bub),   int'(e.stall));
        chk(e.id, "B.flush_ifid",  32'(b_fl_if), int'(e.flush));
        chk(e.id, "B.flush_idex",  32'(b_fl_id), int'(e.flush));
        chk(e.id, "B.flush_exmem", 32'(b_fl_ex), int'(e.flush));
        chk(e.id, "B.fwd_a_sel",   32'(b_fa),    e.fa);
        chk(e.id, "B.fwd_b_sel",   32'(b_fb),    e.fb);
        chk(e.id, "B.stall_cnt",   32'(b_sc),    e.sc);
        chk(e.id, "B.flush_cnt",   32'(b_fc),    e.fc);
      end
    end
  end

  // Drive one cycle of ID inputs just after the rising edge.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic rsu, input logic rtu, input logic [4:0] dst,
                     input logic rw, input logic mr, input logic br, input logic xs);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_dest = dst; id_reg_write = rw; id_mem_read = mr; branch_taken = br; ext_stall = xs;
    step_id++;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
    cyc(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [4:0] rs, input logic [4:0] dst);
    cyc(1'b1, rs, 5'd0, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic ex(input bit d, input bit st, input bit fl, input int fa, input int fb,
                    input int sc, input int fc);
    exp_t e;
    e.dut = d; e.id = step_id; e.stall = st; e.flush = fl;
    e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int sc;
    rst = 1'b1;
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_dest = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; branch_taken = 1'b0; ext_stall = 1'b0;
    #12 rst = 1'b0;

    // Reset state on both instances
    idle(); ex(1'b0, 1'b0, 1'b0, 0, 0, 0, 0); ex(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

    // add r3 ; sub r4,r3,r1 back-to-back -> forward from MEM
    alu(5'd1, 5'd2, 5'd3);  ex(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    alu(5'd3, 5'd1, 5'd4);  ex(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    idle();                 ex(1'b0, 1'b0, 1'b0, 1, 0, 0, 0);
    // one nop between -> forward from WB
    alu(5'd1, 5'd2, 5'd3);
    idle();
    alu(5'd3, 5'd1, 5'd4);
    idle();                 ex(1'b0, 1'b0, 1'b0, 2, 0, 0, 0);
    // destination r0 is never a hazard
    alu(5'd1, 5'd2, 5'd0);
    alu(5'd0, 5'd1, 5'd4);
    idle();                 ex(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    // two producers of r3: youngest wins, on operand B
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd1, 5'd2, 5'd3);
    alu(5'd1, 5'd3, 5'd4);
    idle();                 ex(1'b0, 1'b0, 1'b0, 0, 1, 0, 0);

    // lw r5 ; add r6,r5,r5 -> one stall cycle, then forward from WB
    ld(5'd1, 5'd5);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    idle();                 ex(1'b0, 1'b0, 1'b0, 2, 2, 1, 0);
    // load dest matches only an unused source -> no stall
    ld(5'd1, 5'd5);
    cyc(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 0);
    // load into r0 -> no stall
    ld(5'd1, 5'd0);
    alu(5'd0, 5'd0, 5'd6);  ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 0);

    // beq ; lw r7 ; add r8,r7,r7 with branch taken -> flush beats stall
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ld(5'd1, 5'd7);
    cyc(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    ex(1'b0, 1'b0, 1'b1, 0, 0, 1, 0);
    // instruction in ID during the flush is squashed: no forward from it later
    alu(5'd1, 5'd2, 5'd9);  ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 1);
    alu(5'd9, 5'd1, 5'd10); ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 1);
    idle();                 ex(1'b0, 1'b0, 1'b0, 0, 0, 1, 1);

    // ext_stall held 3 cycles during a load-use; taken branch ignored while frozen
    alu(5'd1, 5'd2, 5'd10);
    ld(5'd1, 5'd5);
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1); ex(1'b0, 1'b1, 1'b0, 0, 0, 1, 1);
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1); ex(1'b0, 1'b1, 1'b0, 0, 0, 1, 1);
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1); ex(1'b0, 1'b1, 1'b0, 0, 0, 1, 1);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b0, 1'b1, 1'b0, 0, 0, 1, 1);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b0, 1'b0, 1'b0, 0, 0, 2, 1);
    idle();                 ex(1'b0, 1'b0, 1'b0, 2, 2, 2, 1);

    // 20 more stall cycles on a 4-bit counter: saturates at 15
    idle();
    sc = 2;
    for (int i = 0; i < 20; i++) begin
      ld(5'd1, 5'd5);
      alu(5'd5, 5'd5, 5'd6); ex(1'b0, 1'b1, 1'b0, 0, 0, sc, 1);
      sc = (sc < 15) ? sc + 1 : 15;
      alu(5'd5, 5'd5, 5'd6); ex(1'b0, 1'b0, 1'b0, 0, 0, sc, 1);
    end
    idle();                 ex(1'b0, 1'b0, 1'b0, 2, 2, 15, 1);

    // Reset pulsed mid-stall with the shadow full
    ld(5'd1, 5'd5);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b0, 1'b1, 1'b0, 0, 0, 15, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    idle(); ex(1'b0, 1'b0, 1'b0, 0, 0, 0, 0); ex(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

    // Instance B (LOAD_LAT=2, FWD_DEPTH=3): two-cycle stall, then forward from stage 3
    ld(5'd1, 5'd5);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b1, 1'b1, 1'b0, 0, 0, 1, 0);
    alu(5'd5, 5'd5, 5'd6);  ex(1'b1, 1'b0, 1'b0, 0, 0, 2, 0);
    idle();                 ex(1'b1, 1'b0, 1'b0, 3, 3, 2, 0);

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
